// File: rtl/mem_scheduler.sv
// mem_scheduler: shares one pipelined main memory between I-cache fills,
// D-cache fills and write-through stores. Fills stall the whole pipeline.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | serve a store, or accept a miss (D before I)
// S_FILL | issue block reads and stream returned words into the cache
// S_DONE | one extra stall cycle so the cache re-lookup sees the tag
module mem_scheduler #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LAT         = 4,
  parameter int ADDR_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_icache_miss,
  input  logic [ADDR_W-1:0] i_icache_miss_addr,
  input  logic              i_dcache_miss,
  input  logic [ADDR_W-1:0] i_dcache_miss_addr,
  input  logic              i_store_en,
  input  logic [ADDR_W-1:0] i_store_addr,
  input  logic [15:0]       i_store_data,
  output logic              o_mem_enable,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_data_in,
  input  logic [15:0]       i_mem_data_out,
  input  logic              i_mem_data_valid,
  output logic [15:0]       o_fill_data,
  output logic [ADDR_W-1:0] o_fill_addr,
  output logic              o_icache_wr_data,
  output logic              o_icache_wr_tag,
  output logic              o_dcache_wr_data,
  output logic              o_dcache_wr_tag,
  output logic              o_fill_sel_d,
  output logic              o_stall_n
);

  localparam int CNT_W = $clog2(WORDS_PER_BLOCK + 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  N_WORDS   = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

  // The read-return path assumes at least one cycle of memory latency.
  generate
    if (MEM_LAT < 1 || WORDS_PER_BLOCK < 2) begin : g_param_check
      $error("mem_scheduler: MEM_LAT must be >= 1 and WORDS_PER_BLOCK >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic              r_sel_d, w_sel_d_nxt;
  logic [CNT_W-1:0]  r_issue_cnt, w_issue_cnt_nxt;
  logic [CNT_W-1:0]  r_recv_cnt, w_recv_cnt_nxt;
  logic              r_store_done, w_store_done_nxt;
  logic              w_store_go;
  logic [ADDR_W-1:0] w_issue_off, w_recv_off;

  // Word offsets within the block; the base is block aligned so no carry.
  assign w_issue_off  = ADDR_W'({r_issue_cnt, 1'b0});
  assign w_recv_off   = ADDR_W'({r_recv_cnt, 1'b0});
  assign o_fill_sel_d = r_sel_d;

  // State, block base, counters and the store de-duplication flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_sel_d      <= 1'b0;
      r_issue_cnt  <= '0;
      r_recv_cnt   <= '0;
      r_store_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_base       <= w_base_nxt;
      r_sel_d      <= w_sel_d_nxt;
      r_issue_cnt  <= w_issue_cnt_nxt;
      r_recv_cnt   <= w_recv_cnt_nxt;
      r_store_done <= w_store_done_nxt;
    end
  end

  // Next-state logic plus memory, cache-write and stall outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_base_nxt       = r_base;
    w_sel_d_nxt      = r_sel_d;
    w_issue_cnt_nxt  = r_issue_cnt;
    w_recv_cnt_nxt   = r_recv_cnt;
    w_store_go       = 1'b0;
    o_mem_enable     = 1'b0;
    o_mem_wr         = 1'b0;
    o_mem_addr       = '0;
    o_mem_data_in    = '0;
    o_fill_data      = '0;
    o_fill_addr      = '0;
    o_icache_wr_data = 1'b0;
    o_icache_wr_tag  = 1'b0;
    o_dcache_wr_data = 1'b0;
    o_dcache_wr_tag  = 1'b0;
    o_stall_n        = 1'b1;

    case (r_state)
      S_IDLE: begin
        o_stall_n = ~(i_icache_miss | i_dcache_miss);
        if (i_store_en && !r_store_done) begin
          w_store_go    = 1'b1;
          o_mem_enable  = 1'b1;
          o_mem_wr      = 1'b1;
          o_mem_addr    = i_store_addr;
          o_mem_data_in = i_store_data;
        end else if (i_dcache_miss) begin
          w_base_nxt      = i_dcache_miss_addr & ~OFF_MASK;
          w_sel_d_nxt     = 1'b1;
          w_issue_cnt_nxt = '0;
          w_recv_cnt_nxt  = '0;
          w_state_nxt     = S_FILL;
        end else if (i_icache_miss) begin
          w_base_nxt      = i_icache_miss_addr & ~OFF_MASK;
          w_sel_d_nxt     = 1'b0;
          w_issue_cnt_nxt = '0;
          w_recv_cnt_nxt  = '0;
          w_state_nxt     = S_FILL;
        end
      end
      S_FILL: begin
        o_stall_n = 1'b0;
        if (r_issue_cnt < N_WORDS) begin
          o_mem_enable    = 1'b1;
          o_mem_addr      = r_base + w_issue_off;
          w_issue_cnt_nxt = r_issue_cnt + 1'b1;
        end
        if (i_mem_data_valid) begin
          o_fill_data      = i_mem_data_out;
          o_fill_addr      = r_base + w_recv_off;
          o_dcache_wr_data = r_sel_d;
          o_icache_wr_data = ~r_sel_d;
          w_recv_cnt_nxt   = r_recv_cnt + 1'b1;
          if (r_recv_cnt == LAST_WORD) begin
            o_dcache_wr_tag = r_sel_d;
            o_icache_wr_tag = ~r_sel_d;
            w_state_nxt     = S_DONE;
          end
        end
      end
      S_DONE: begin
        o_stall_n   = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A store issued while frozen must not repeat until the pipeline moves.
    if (o_stall_n) begin
      w_store_done_nxt = 1'b0;
    end else if (w_store_go) begin
      w_store_done_nxt = 1'b1;
    end else begin
      w_store_done_nxt = r_store_done;
    end
  end

endmodule

// File: tb/tb_mem_scheduler.sv
// tb_mem_scheduler: scoreboard bench with a latency-programmable memory stub.
module tb_mem_scheduler;
  localparam int WPB = 8;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_miss = 1'b0, dcache_miss = 1'b0, store_en = 1'b0;
  logic [15:0] icache_miss_addr = '0, dcache_miss_addr = '0;
  logic [15:0] store_addr = '0, store_data = '0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data_out = '0;
  logic        o_mem_enable, o_mem_wr, o_icache_wr_data, o_icache_wr_tag;
  logic        o_dcache_wr_data, o_dcache_wr_tag, o_fill_sel_d, o_stall_n;
  logic [15:0] o_mem_addr, o_mem_data_in, o_fill_data, o_fill_addr;

  mem_scheduler #(.WORDS_PER_BLOCK(WPB), .MEM_LAT(LAT), .ADDR_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_icache_miss(icache_miss), .i_icache_miss_addr(icache_miss_addr),
    .i_dcache_miss(dcache_miss), .i_dcache_miss_addr(dcache_miss_addr),
    .i_store_en(store_en), .i_store_addr(store_addr), .i_store_data(store_data),
    .o_mem_enable(o_mem_enable), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr),
    .o_mem_data_in(o_mem_data_in), .i_mem_data_out(mem_data_out),
    .i_mem_data_valid(mem_data_valid), .o_fill_data(o_fill_data),
    .o_fill_addr(o_fill_addr), .o_icache_wr_data(o_icache_wr_data),
    .o_icache_wr_tag(o_icache_wr_tag), .o_dcache_wr_data(o_dcache_wr_data),
    .o_dcache_wr_tag(o_dcache_wr_tag), .o_fill_sel_d(o_fill_sel_d),
    .o_stall_n(o_stall_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] data; } mem_ev_t;
  typedef struct { int cyc; logic sel_d; logic [15:0] addr; logic [15:0] data; logic tag; } fill_ev_t;
  typedef struct { int rdy; logic [15:0] data; } rd_t;

  mem_ev_t  mq[$];
  fill_ev_t fq[$];
  rd_t      rq[$];
  int       extra_lat = 0;
  logic [15:0] salt = 16'h5A3C;
  int       n_checks = 0, n_pass = 0;
  int       stall_cnt = 0;
  logic     last_itag = 1'b0, last_dtag = 1'b0, last_stall_hi = 1'b1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail(input string nm, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: got %0h expected no such event (cycle %0d)", nm, act, cyc);
  endtask

  // Reference model: a fill of the block containing miss_addr starting at
  // cycle 'start' reads word k at start+1+k and writes it at start+1+LAT+k.
  function automatic void plan_fill(input logic [15:0] miss_addr, input logic sel_d,
                                    input int start, input int n_iss, input int n_rcv,
                                    input bit timed);
    int base = int'(miss_addr) - (int'(miss_addr) % (2 * WPB));
    for (int k = 0; k < n_iss; k++)
      mq.push_back('{cyc: timed ? start + 1 + k : -1, wr: 1'b0,
                     addr: 16'(base + 2 * k), data: 16'h0});
    for (int k = 0; k < n_rcv; k++)
      fq.push_back('{cyc: timed ? start + 1 + LAT + k : -1, sel_d: sel_d,
                     addr: 16'(base + 2 * k), data: mem_word(16'(base + 2 * k)),
                     tag: (k == WPB - 1)});
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a memory request
  // or a cache write; also feeds the memory stub and records stall cycles.
  always @(negedge clk) begin
    mem_ev_t  me;
    fill_ev_t fe;
    if (!o_stall_n) stall_cnt++;
    if (o_mem_enable) begin
      if (mq.size() == 0) fail("mem_unexpected", {o_mem_wr, o_mem_addr, o_mem_data_in});
      else begin
        me = mq.pop_front();
        chk("mem_op", {o_mem_wr, o_mem_addr, o_mem_data_in}, {me.wr, me.addr, me.data});
        if (me.cyc >= 0) chk("mem_cycle", cyc, me.cyc);
      end
      if (!o_mem_wr) rq.push_back('{rdy: cyc + LAT + extra_lat, data: mem_word(o_mem_addr)});
    end
    if (o_icache_wr_data && o_dcache_wr_data)
      fail("both_caches", {o_icache_wr_data, o_dcache_wr_data});
    else if (o_icache_wr_data || o_dcache_wr_data) begin
      if (fq.size() == 0) fail("fill_unexpected", {o_dcache_wr_data, o_fill_addr, o_fill_data});
      else begin
        fe = fq.pop_front();
        chk("fill_word",
            {o_dcache_wr_data, o_fill_sel_d, o_icache_wr_tag, o_dcache_wr_tag, o_fill_addr, o_fill_data},
            {fe.sel_d, fe.sel_d, fe.tag & ~fe.sel_d, fe.tag & fe.sel_d, fe.addr, fe.data});
        if (fe.cyc >= 0) chk("fill_cycle", cyc, fe.cyc);
      end
    end else if (o_icache_wr_tag || o_dcache_wr_tag)
      fail("tag_without_data", {o_icache_wr_tag, o_dcache_wr_tag});
    last_itag     = o_icache_wr_tag;
    last_dtag     = o_dcache_wr_tag;
    last_stall_hi = o_stall_n;
    if (rst) rq.delete();
  end

  // Memory stub: each read returns its word when its ready cycle arrives.
  always @(posedge clk) begin
    #1;
    while (rq.size() > 0 && rq[0].rdy < cyc) void'(rq.pop_front());
    if (rq.size() > 0 && rq[0].rdy == cyc) begin
      mem_data_valid = 1'b1;
      mem_data_out   = rq[0].data;
    end else begin
      mem_data_valid = 1'b0;
      mem_data_out   = 16'($urandom);
    end
  end

  // One cycle; the caches drop a miss after their tag write, and the MEM stage
  // retires a store after a cycle without stall.
  task automatic step();
    @(posedge clk);
    #1;
    if (last_itag) icache_miss = 1'b0;
    if (last_dtag) dcache_miss = 1'b0;
    if (last_stall_hi && store_en) store_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_flags"}, {o_mem_enable, o_mem_wr, o_icache_wr_data, o_icache_wr_tag,
                         o_dcache_wr_data, o_dcache_wr_tag, o_fill_sel_d, o_stall_n}, 8'b0000_0001);
    chk({nm, "_buses"}, {o_mem_addr, o_mem_data_in, o_fill_data, o_fill_addr}, 64'h0);
  endtask

  task automatic drain_and_check(input int n0, input int s0, input int exp_stall, input bit timed);
    for (int k = 0; k < 200; k++) begin
      step();
      if (mq.size() == 0 && fq.size() == 0 && !icache_miss && !dcache_miss &&
          !store_en && last_stall_hi) break;
    end
    step();
    step();
    chk("drained", {32'(mq.size()), 32'(fq.size())}, 64'h0);
    if (timed) chk("stall_cycles", stall_cnt - s0, exp_stall);
    if (cyc - n0 > 150) fail("scenario_timeout", cyc - n0);
  endtask

  task automatic run_scn(input bit di, input bit dd, input bit ds,
                         input logic [15:0] ia, input logic [15:0] da,
                         input logic [15:0] sa, input logic [15:0] sd, input int xl);
    int n, s0, t, nf;
    bit timed;
    timed = (xl == 0);
    extra_lat = xl;
    step();
    n  = cyc;
    s0 = stall_cnt;
    icache_miss = di; icache_miss_addr = ia;
    dcache_miss = dd; dcache_miss_addr = da;
    store_en = ds; store_addr = sa; store_data = sd;
    t  = n;
    nf = 0;
    if (ds) begin
      mq.push_back('{cyc: n, wr: 1'b1, addr: sa, data: sd});
      if (di || dd) t = n + 1;
    end
    if (dd) begin plan_fill(da, 1'b1, t, WPB, WPB, timed); t += 14; nf++; end
    if (di) begin plan_fill(ia, 1'b0, t, WPB, WPB, timed); nf++; end
    drain_and_check(n, s0, ((ds && nf > 0) ? 1 : 0) + 14 * nf, timed);
  endtask

  // D fill interrupted by reset during its 7th read; nothing after that may appear.
  task automatic run_reset_mid_fill(input logic [15:0] da);
    int n;
    extra_lat = 0;
    step();
    n = cyc;
    dcache_miss = 1'b1; dcache_miss_addr = da;
    plan_fill(da, 1'b1, n, 7, 3, 1'b1);
    repeat (7) step();
    rst = 1'b1;
    dcache_miss = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_cycle", cyc, n + 8);
    chk_reset_outputs("rst_mid_fill");
    repeat (12) step();
    chk("rst_drained", {32'(mq.size()), 32'(fq.size())}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb, rc, rd;
    int xl;
    salt = 16'($urandom);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    run_scn(1'b1, 1'b0, 1'b0, 16'h0136, 16'h0000, 16'h0000, 16'h0000, 0);
    run_scn(1'b1, 1'b1, 1'b0, 16'h0040, 16'h2008, 16'h0000, 16'h0000, 0);
    run_scn(1'b1, 1'b0, 1'b1, 16'h0136, 16'h0000, 16'h1000, 16'hBEEF, 0);
    run_scn(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h3456, 16'hCAFE, 0);
    run_reset_mid_fill(16'h2008);
    run_scn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h4A7E, 16'h0000, 16'h0000, 0);
    run_scn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h7F1A, 16'h0000, 16'h0000, LAT);

    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom); rd = 16'($urandom);
      xl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      run_scn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ra, rb, rc, rd, xl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
